// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared types for the instruction-fetch front end: fetch FSM
//                state encoding, instruction word size and the buffered
//                fetch-entry record (PC plus instruction word).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        WAIT_R = 2'd2,
        ACK    = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/axi_ifetch_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ifetch_master_if
//  Description : AXI4-Lite read channels (AR and R) between the fetch master
//                and the instruction ROM slave.
//  Ports       : m_araddr/m_arvalid/m_arready - read address channel
//                m_rdata/m_rvalid/m_rready    - read data channel
//                modport master drives AR and rready, modport slave the rest
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_ifetch_master_if;

    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_araddr,
        output m_arvalid,
        output m_rready,
        input  m_arready,
        input  m_rdata,
        input  m_rvalid
    );

    modport slave (
        input  m_araddr,
        input  m_arvalid,
        input  m_rready,
        output m_arready,
        output m_rdata,
        output m_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_fifo
//  Description : Synchronous instruction buffer of FIFO_DEPTH fetch entries.
//                Wrapping log2(FIFO_DEPTH)-bit pointers plus an occupancy
//                count. Flush empties the buffer and overrides push/pop.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                push, push_entry  - write one entry at the tail
//                pop               - drop the head entry
//                flush             - discard all entries
//                count             - current occupancy (0..FIFO_DEPTH)
//                head              - entry at the head (storage read, no logic
//                                    from push/pop inputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  fetch_entry_t                  push_entry,
    input  logic                          pop,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output fetch_entry_t                  head
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_entry_t     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_push = push && (count_q != DEPTH_C);
    assign do_pop  = pop  && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/axi_ifetch_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ifetch_master
//  Description : Instruction-fetch front end. Owns the fetch PC, issues one
//                AXI4-Lite read at a time (only when a buffer slot is free),
//                and queues {pc, instr} entries for the core. A redirect
//                retargets the PC, flushes the buffer and marks any in-flight
//                read to be discarded.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                bus (master modport)       - AXI4-Lite AR/R channels
//                redirect_valid/redirect_pc - one-cycle PC redirect
//                if_valid/if_pc/if_instr    - head entry to the core
//                if_ready                   - core accepts head entry
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_ifetch_master
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4   // power of 2, >= 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_ifetch_master_if.master    bus,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   if_valid,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_instr,
    input  logic                   if_ready
);

    localparam int               CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      RESET_PC_A = RESET_PC & ~32'h3;

    fetch_state_t state, state_n;
    logic [31:0]  araddr,   araddr_n;
    logic         arvalid,  arvalid_n;
    logic         rready,   rready_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  req_pc,   req_pc_n;
    logic         kill,     kill_n;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_after;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             push;
    logic             pop;
    logic             ar_hs;
    logic             r_hs;
    logic [31:0]      target_pc;

    assign target_pc  = redirect_pc & ~32'h3;
    assign ar_hs      = arvalid && bus.m_arready;
    assign r_hs       = (state == ACK) && rready && bus.m_rvalid;
    // A response arriving under kill, or together with a redirect, belongs
    // to the abandoned path and is dropped.
    assign push       = r_hs && !kill && !redirect_valid;
    // Redirect flushes the buffer, so a same-cycle pop has no effect.
    assign pop        = if_valid && if_ready && !redirect_valid;
    assign push_entry = '{pc: req_pc, instr: bus.m_rdata};
    assign count_after = redirect_valid ? '0
                       : fifo_count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            araddr   <= RESET_PC_A;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            fetch_pc <= RESET_PC_A;
            req_pc   <= RESET_PC_A;
            kill     <= 1'b0;
        end else begin
            state    <= state_n;
            araddr   <= araddr_n;
            arvalid  <= arvalid_n;
            rready   <= rready_n;
            fetch_pc <= fetch_pc_n;
            req_pc   <= req_pc_n;
            kill     <= kill_n;
        end
    end

    always_comb begin
        state_n    = state;
        araddr_n   = araddr;
        arvalid_n  = arvalid;
        rready_n   = rready;
        req_pc_n   = req_pc;
        kill_n     = kill;
        fetch_pc_n = redirect_valid ? target_pc : fetch_pc;

        case (state)
            IDLE: begin
                // A redirect empties the buffer, so a slot is free and the
                // request can go straight out to the new target.
                if ((fifo_count < DEPTH_C) || redirect_valid) begin
                    state_n   = ADDR;
                    araddr_n  = fetch_pc_n;
                    arvalid_n = 1'b1;
                end
            end
            ADDR: begin
                // arvalid is never withdrawn once raised; a redirect only
                // marks the eventual response for discard.
                if (redirect_valid) begin
                    kill_n = 1'b1;
                end
                if (ar_hs) begin
                    state_n   = WAIT_R;
                    req_pc_n  = araddr;
                    arvalid_n = 1'b0;
                    if (!redirect_valid) begin
                        fetch_pc_n = fetch_pc + 32'(WORD_BYTES);
                    end
                end
            end
            WAIT_R: begin
                rready_n = 1'b0;
                if (redirect_valid) begin
                    kill_n = 1'b1;
                end
                if (bus.m_rvalid) begin
                    state_n  = ACK;
                    rready_n = 1'b1;
                end
            end
            ACK: begin
                if (r_hs) begin
                    kill_n   = 1'b0;
                    rready_n = 1'b0;
                    if (count_after < DEPTH_C) begin
                        state_n   = ADDR;
                        araddr_n  = fetch_pc_n;
                        arvalid_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (redirect_valid) begin
                    kill_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    ifetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head       (head)
    );

    assign bus.m_araddr  = araddr;
    assign bus.m_arvalid = arvalid;
    assign bus.m_rready  = rready;

    assign if_valid = (fifo_count != '0);
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

endmodule
`default_nettype wire

// File: tb/tb_axi_ifetch_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_ifetch_master
//  Description : Directed self-checking bench for axi_ifetch_master with a
//                read-only ROM slave model (rvalid 3 cycles after the AR
//                handshake, optional arready stall) and a consumer monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ifetch_master;

    localparam int RLAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;

    axi_ifetch_master_if bus();

    axi_ifetch_master #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'd17;
    endfunction

    // Logs filled by the slave/monitor process.
    logic [31:0] ar_addr [$];
    int          ar_cyc  [$];
    logic [31:0] pop_pc  [$];
    logic [31:0] pop_ins [$];
    int          pop_cyc [$];
    int          first_arv_cyc = -1;
    int          stall = 0;
    int          ar_viol = 0;
    int          rready_viol = 0;

    // ROM slave plus consumer monitor; acts on the falling edge so that
    // everything it drives or samples is away from the active edge.
    initial begin
        int          rcnt;
        int          ar_wait;
        bit          r_done;
        bit          prev_stall;
        logic [31:0] r_addr;
        logic [31:0] prev_addr;
        rcnt = 0; ar_wait = 0; r_done = 0; prev_stall = 0; r_addr = '0; prev_addr = '0;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.m_arready = 1'b0;
                bus.m_rvalid  = 1'b0;
                rcnt = 0; ar_wait = 0; r_done = 0; prev_stall = 0;
            end else begin
                if (r_done) begin
                    bus.m_rvalid = 1'b0;
                    r_done = 0;
                end
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rdata  = rom(r_addr);
                    end
                end
                if (bus.m_rready && !bus.m_rvalid) rready_viol++;
                if (bus.m_rvalid && bus.m_rready) r_done = 1;
                if (prev_stall && !(bus.m_arvalid && bus.m_araddr == prev_addr)) ar_viol++;
                if (bus.m_arvalid && bus.m_araddr[1:0] != 2'b00) ar_viol++;
                if (bus.m_arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
                if (bus.m_arvalid) begin
                    if (ar_wait < stall) begin
                        bus.m_arready = 1'b0;
                        ar_wait++;
                    end else begin
                        bus.m_arready = 1'b1;
                        ar_wait = 0;
                        ar_addr.push_back(bus.m_araddr);
                        ar_cyc.push_back(cyc);
                        r_addr = bus.m_araddr;
                        rcnt = RLAT;
                    end
                end else begin
                    bus.m_arready = 1'b0;
                end
                prev_stall = bus.m_arvalid && !bus.m_arready;
                prev_addr  = bus.m_araddr;
                if (if_valid && if_ready && !redirect_valid) begin
                    pop_pc.push_back(if_pc);
                    pop_ins.push_back(if_instr);
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ar_addr.delete(); ar_cyc.delete();
        pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
        first_arv_cyc = -1; ar_viol = 0; rready_viol = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        clear_logs();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ar(input int n, input string tag);
        int t = 0;
        while (ar_addr.size() < n && t < 200) begin tick(); t++; end
        if (ar_addr.size() < n) check_eq(tag, 32'(ar_addr.size()), 32'(n));
    endtask

    task automatic wait_pop(input int n, input string tag);
        int t = 0;
        while (pop_pc.size() < n && t < 200) begin tick(); t++; end
        if (pop_pc.size() < n) check_eq(tag, 32'(pop_pc.size()), 32'(n));
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int t;
        int acks;
        int npop;

        // ---- reset state -------------------------------------------------
        stall = 0;
        if_ready = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        check_eq("rst_arvalid", 32'(bus.m_arvalid), 32'd0);
        check_eq("rst_rready",  32'(bus.m_rready),  32'd0);
        check_eq("rst_araddr",  bus.m_araddr,       32'h0);
        check_eq("rst_if_valid", 32'(if_valid),     32'd0);
        check_eq("rst_if_pc",    if_pc,             32'h0);
        check_eq("rst_if_instr", if_instr,          32'h0);

        // ---- 1: streaming fetch, 5-cycle cadence -------------------------
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t1_arvalid_pre", 32'(bus.m_arvalid), 32'd0);
        tick();
        check_eq("t1_arvalid_first", 32'(bus.m_arvalid), 32'd1);
        wait_pop(3, "t1_pop_timeout");
        check_eq("t1_pc0",  pop_pc[0],  32'h0);
        check_eq("t1_in0",  pop_ins[0], 32'h11);
        check_eq("t1_pc1",  pop_pc[1],  32'h4);
        check_eq("t1_in1",  pop_ins[1], 32'h22);
        check_eq("t1_pc2",  pop_pc[2],  32'h8);
        check_eq("t1_in2",  pop_ins[2], 32'h33);
        check_eq("t1_lat",  32'(pop_cyc[0] - ar_cyc[0]), 32'd5);
        check_eq("t1_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd5);
        check_eq("t1_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd5);

        // ---- 2: backpressure fills the buffer ----------------------------
        if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 60; i++) tick();
        check_eq("t2_hs_count",  32'(ar_addr.size()), 32'd4);
        check_eq("t2_arvalid",   32'(bus.m_arvalid),  32'd0);
        check_eq("t2_if_valid",  32'(if_valid),       32'd1);
        check_eq("t2_head_pc",   if_pc,               32'h0);
        check_eq("t2_head_ins",  if_instr,            32'h11);
        if_ready = 1'b1;
        wait_ar(5, "t2_ar_timeout");
        check_eq("t2_resume_addr", ar_addr[4], 32'h10);
        wait_pop(5, "t2_pop_timeout");
        check_eq("t2_pc4", pop_pc[4],  32'h10);
        check_eq("t2_in4", pop_ins[4], 32'h55);

        // ---- 3: redirect while waiting for the 0x8 response ---------------
        if_ready = 1'b1;
        do_reset();
        wait_ar(3, "t3_ar_timeout");
        check_eq("t3_inflight_addr", ar_addr[2], 32'h8);
        npop = pop_pc.size();
        pulse_redirect(32'h0000_0103);
        check_eq("t3_flushed", 32'(if_valid), 32'd0);
        check_eq("t3_npop", 32'(npop), 32'd2);
        wait_ar(4, "t3_ar2_timeout");
        check_eq("t3_next_addr", ar_addr[3], 32'h100);
        wait_pop(npop + 1, "t3_pop_timeout");
        check_eq("t3_pc", pop_pc[npop],  32'h100);
        check_eq("t3_in", pop_ins[npop], 32'h451);

        // ---- 4: redirect on the AR handshake for 0x4 ----------------------
        do_reset();
        t = 0;
        while (!(bus.m_arvalid && bus.m_araddr == 32'h4) && t < 100) begin tick(); t++; end
        check_eq("t4_found_hs", 32'(bus.m_araddr), 32'h4);
        pulse_redirect(32'h0000_0040);
        check_eq("t4_flushed", 32'(if_valid), 32'd0);
        wait_ar(3, "t4_ar_timeout");
        check_eq("t4_addr1", ar_addr[1], 32'h4);
        check_eq("t4_addr2", ar_addr[2], 32'h40);
        wait_pop(1, "t4_pop_timeout");
        check_eq("t4_pc0", pop_pc[0],  32'h40);
        check_eq("t4_in0", pop_ins[0], 32'h121);

        // ---- 5: arready stalled for 3 cycles ------------------------------
        stall = 3;
        do_reset();
        wait_pop(2, "t5_pop_timeout");
        check_eq("t5_stall_len", 32'(ar_cyc[0] - first_arv_cyc), 32'd3);
        check_eq("t5_ar_stable", 32'(ar_viol),     32'd0);
        check_eq("t5_rready_early", 32'(rready_viol), 32'd0);
        check_eq("t5_pc0", pop_pc[0],  32'h0);
        check_eq("t5_in0", pop_ins[0], 32'h11);
        check_eq("t5_pc1", pop_pc[1],  32'h4);
        check_eq("t5_in1", pop_ins[1], 32'h22);
        stall = 0;

        // ---- 6: reset asserted during ACK --------------------------------
        if_ready = 1'b0;
        do_reset();
        acks = 0; t = 0;
        while (acks < 2 && t < 100) begin
            tick(); t++;
            if (bus.m_rready) acks++;
        end
        check_eq("t6_ack_seen",   32'(acks),      32'd2);
        check_eq("t6_pre_valid",  32'(if_valid),  32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_arvalid", 32'(bus.m_arvalid), 32'd0);
        check_eq("t6_rready",  32'(bus.m_rready),  32'd0);
        check_eq("t6_araddr",  bus.m_araddr,       32'h0);
        check_eq("t6_if_valid", 32'(if_valid),     32'd0);
        check_eq("t6_if_pc",    if_pc,             32'h0);
        check_eq("t6_if_instr", if_instr,          32'h0);
        clear_logs();
        tick(); tick();
        rst_n = 1'b1;
        if_ready = 1'b1;
        wait_pop(1, "t6_pop_timeout");
        check_eq("t6_restart_addr", ar_addr[0], 32'h0);
        check_eq("t6_pc0", pop_pc[0],  32'h0);
        check_eq("t6_in0", pop_ins[0], 32'h11);

        // ---- 7: PC wraps past the top of the address space ---------------
        do_reset();
        wait_ar(1, "t7_ar_timeout");
        pulse_redirect(32'hFFFF_FFFF);
        wait_ar(3, "t7_ar2_timeout");
        check_eq("t7_addr_top",  ar_addr[1], 32'hFFFF_FFFC);
        check_eq("t7_addr_wrap", ar_addr[2], 32'h0);
        wait_pop(2, "t7_pop_timeout");
        check_eq("t7_pc0", pop_pc[0],  32'hFFFF_FFFC);
        check_eq("t7_in0", pop_ins[0], 32'h4000_0000);
        check_eq("t7_pc1", pop_pc[1],  32'h0);
        check_eq("t7_in1", pop_ins[1], 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
